// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter and its reusable picker.
package wb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_RELEASE = 2'd2
  } arbState_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int WB_WIDTH    = 32;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Requester-side and shared-bus signal bundle for wb_bus_arbiter.
// oTimeout exists only when WB_ARB_WATCHDOG_EN is defined.
interface wb_bus_arbiter_if
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ),
  parameter int WB_W    = WB_WIDTH
);

  logic [NUM_REQ-1:0]      iCYC;
  logic [NUM_REQ-1:0]      iSTB;
  logic [NUM_REQ-1:0]      iWE;
  logic [NUM_REQ*WB_W-1:0] iADR;
  logic [NUM_REQ*WB_W-1:0] iDAT;
  logic [NUM_REQ-1:0]      oGNT;
  logic [NUM_REQ-1:0]      oACK;
  logic [WB_W-1:0]         oDAT;
  logic                    CYC_O;
  logic                    STB_O;
  logic                    WE_O;
  logic [WB_W-1:0]         ADR_O;
  logic [WB_W-1:0]         DAT_O;
  logic [WB_W-1:0]         DAT_I;
  logic                    ACK_I;
  logic [IDX_W-1:0]        oOwner;
  logic                    oBusy;
`ifdef WB_ARB_WATCHDOG_EN
  logic                    oTimeout;
`endif

  // Arbiter view: drives grants and the shared bus, listens to requesters and slave.
  modport master (
    input  iCYC, iSTB, iWE, iADR, iDAT, DAT_I, ACK_I,
`ifdef WB_ARB_WATCHDOG_EN
    output oTimeout,
`endif
    output oGNT, oACK, oDAT, CYC_O, STB_O, WE_O, ADR_O, DAT_O, oOwner, oBusy
  );

  modport slave (
    output iCYC, iSTB, iWE, iADR, iDAT, DAT_I, ACK_I,
`ifdef WB_ARB_WATCHDOG_EN
    input  oTimeout,
`endif
    input  oGNT, oACK, oDAT, CYC_O, STB_O, WE_O, ADR_O, DAT_O, oOwner, oBusy
  );

endinterface

// File: rtl/wb_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester strictly after the last winner,
// with wrap-around. Shared with the TMEM arbiter.
module rr_priority_pick
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               any
);

  always_comb begin
    int k;
    k        = 0;
    grant    = '0;
    grantIdx = '0;
    any      = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      k = (int'(last) + off) % NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        grantIdx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among NUM_REQ requesters.
// Optional owner watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int IDX_W          = 2,
  parameter int WB_W           = WB_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              Clock,
  input logic              Reset,
  wb_bus_arbiter_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ)) begin : gBadReqCfg
    $error("wb_bus_arbiter: NUM_REQ must be 2..8 and IDX_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeoutCfg
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  arbState_t          state;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] reqVec;
  logic [NUM_REQ-1:0] pickOneHot;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickAny;
  logic               busy;
  logic               ownerCyc;
  logic               timeoutHit;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPick (
    .req      (reqVec),
    .last     (ptr),
    .grant    (pickOneHot),
    .grantIdx (pickIdx),
    .any      (pickAny)
  );

  assign busy     = (state == ARB_OWN);
  assign ownerCyc = bus.iCYC[int'(owner)];

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0]        wdCnt;
  logic [NUM_REQ-1:0] blocked;

  // A revoked requester stays masked until its CYC has been seen low once.
  assign reqVec       = bus.iCYC & ~blocked;
  assign timeoutHit   = busy && bus.STB_O && !bus.ACK_I && (wdCnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.oTimeout = timeoutHit;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wdCnt   <= '0;
      blocked <= '0;
    end else begin
      blocked <= (blocked & bus.iCYC) | (timeoutHit ? gnt : '0);
      if (!busy || bus.ACK_I)
        wdCnt <= '0;
      else if (bus.STB_O)
        wdCnt <= wdCnt + 16'd1;
    end
  end
`else
  assign reqVec     = bus.iCYC;
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pickAny) begin
            gnt   <= pickOneHot;
            owner <= pickIdx;
            state <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (!ownerCyc || timeoutHit) begin
            gnt   <= '0;
            ptr   <= owner;
            state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  // Shared bus follows the owner's slot combinationally and is forced to 0 outside OWN.
  assign bus.oGNT   = gnt;
  assign bus.oOwner = owner;
  assign bus.oBusy  = busy;
  assign bus.CYC_O  = busy;
  assign bus.STB_O  = busy && bus.iSTB[int'(owner)] && ownerCyc;
  assign bus.WE_O   = busy && bus.iWE[int'(owner)];
  assign bus.ADR_O  = busy ? bus.iADR[int'(owner)*WB_W +: WB_W] : '0;
  assign bus.DAT_O  = busy ? bus.iDAT[int'(owner)*WB_W +: WB_W] : '0;
  // An ACK landing in the cycle the owner drops CYC is not forwarded.
  assign bus.oACK   = (busy && bus.ACK_I && ownerCyc) ? gnt : '0;
  assign bus.oDAT   = bus.DAT_I;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (default build, watchdog disabled).
module tb_wb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int W    = 32;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  wb_bus_arbiter_if #(.NUM_REQ(NREQ), .IDX_W(IW), .WB_W(W)) bus ();

  wb_bus_arbiter #(
    .NUM_REQ        (NREQ),
    .IDX_W          (IW),
    .WB_W           (W),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // Returns at the negedge of the first OWN cycle; gap counts idle-bus cycles seen.
  task automatic waitGrant(output int gap);
    gap = 0;
    forever begin
      @(negedge Clock);
      if (bus.CYC_O === 1'b1) break;
      gap++;
      if (gap > 20) begin
        checkVal("grant_wait_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic clearInputs();
    bus.iCYC  = '0;
    bus.iSTB  = '0;
    bus.iWE   = '0;
    bus.iADR  = '0;
    bus.iDAT  = '0;
    bus.DAT_I = '0;
    bus.ACK_I = 1'b0;
  endtask

  task automatic doReset();
    Reset = 1'b0;
    clearInputs();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  int gap;
  logic [NREQ-1:0] expGnt;

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b0;
    clearInputs();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkVal("rst_gnt",   64'(bus.oGNT),   64'h0);
    checkVal("rst_cyc",   64'(bus.CYC_O),  64'h0);
    checkVal("rst_stb",   64'(bus.STB_O),  64'h0);
    checkVal("rst_busy",  64'(bus.oBusy),  64'h0);
    checkVal("rst_owner", 64'(bus.oOwner), 64'h0);
    checkVal("rst_ack",   64'(bus.oACK),   64'h0);
    checkVal("rst_adr",   64'(bus.ADR_O),  64'h0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    // Single requester: grant one cycle after request, data and ACK routing.
    nextCycle();
    bus.iCYC = 4'b0001;
    bus.iSTB = 4'b0001;
    bus.iADR[0*W +: W] = 32'h100;
    @(negedge Clock);
    checkVal("t1_gnt_same_cycle", 64'(bus.oGNT), 64'h0);
    nextCycle();
    @(negedge Clock);
    checkVal("t1_gnt",   64'(bus.oGNT),  64'h1);
    checkVal("t1_cyc",   64'(bus.CYC_O), 64'h1);
    checkVal("t1_stb",   64'(bus.STB_O), 64'h1);
    checkVal("t1_adr",   64'(bus.ADR_O), 64'h100);
    checkVal("t1_busy",  64'(bus.oBusy), 64'h1);
    nextCycle();
    bus.ACK_I = 1'b1;
    bus.DAT_I = 32'hDEADBEEF;
    @(negedge Clock);
    checkVal("t1_ack",  64'(bus.oACK), 64'h1);
    checkVal("t1_odat", 64'(bus.oDAT), 64'hDEADBEEF);
    nextCycle();
    bus.ACK_I = 1'b0;
    bus.iCYC  = '0;
    bus.iSTB  = '0;
    nextCycle();
    @(negedge Clock);
    checkVal("t1_release_cyc", 64'(bus.CYC_O), 64'h0);
    checkVal("t1_release_gnt", 64'(bus.oGNT),  64'h0);
    checkVal("t1_release_adr", 64'(bus.ADR_O), 64'h0);

    // All four requesting: strict rotation 0,1,2,3,0 with a 2-cycle idle gap.
    doReset();
    bus.iCYC = 4'b1111;
    bus.iSTB = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = n % NREQ;
      waitGrant(gap);
      expGnt = '0;
      expGnt[w] = 1'b1;
      checkVal($sformatf("rr_gnt_%0d", n),   64'(bus.oGNT),   64'(expGnt));
      checkVal($sformatf("rr_owner_%0d", n), 64'(bus.oOwner), 64'(w));
      if (n > 0) checkVal($sformatf("rr_gap_%0d", n), 64'(gap), 64'd2);
      nextCycle();
      bus.ACK_I = 1'b1;
      @(negedge Clock);
      checkVal($sformatf("rr_ack_%0d", n), 64'(bus.oACK), 64'(expGnt));
      nextCycle();
      bus.ACK_I  = 1'b0;
      bus.iCYC[w] = 1'b0;
      nextCycle();
      bus.iCYC[w] = 1'b1;
    end

    // Owner 2 holds the bus while requester 1 waits; handoff two cycles after release.
    doReset();
    bus.iCYC = 4'b0100;
    bus.iSTB = 4'b0100;
    waitGrant(gap);
    checkVal("np_gnt2", 64'(bus.oGNT), 64'h4);
    nextCycle();
    bus.iCYC[1] = 1'b1;
    bus.iSTB[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      checkVal($sformatf("np_hold_%0d", c), 64'(bus.oGNT), 64'h4);
      nextCycle();
    end
    bus.iCYC[2] = 1'b0;
    nextCycle();
    @(negedge Clock);
    checkVal("np_gap1", 64'(bus.oGNT), 64'h0);
    nextCycle();
    @(negedge Clock);
    checkVal("np_gap2", 64'(bus.oGNT), 64'h0);
    nextCycle();
    @(negedge Clock);
    checkVal("np_gnt1", 64'(bus.oGNT), 64'h2);

    // ACK isolation for owner 1 and drop of ACK coinciding with CYC falling.
    nextCycle();
    bus.ACK_I = 1'b1;
    bus.DAT_I = 32'h12345678;
    @(negedge Clock);
    checkVal("iso_ack",  64'(bus.oACK), 64'h2);
    checkVal("iso_odat", 64'(bus.oDAT), 64'h12345678);
    nextCycle();
    bus.iCYC[1] = 1'b0;
    @(negedge Clock);
    checkVal("drop_ack", 64'(bus.oACK), 64'h0);
    nextCycle();
    bus.ACK_I = 1'b0;
    bus.iSTB  = '0;

    // Asynchronous reset in the middle of an active transfer.
    bus.iCYC = 4'b1000;
    bus.iSTB = 4'b1000;
    bus.iWE  = 4'b1000;
    bus.iADR[3*W +: W] = 32'h33;
    bus.iDAT[3*W +: W] = 32'hA5A5;
    waitGrant(gap);
    checkVal("ar_gnt3", 64'(bus.oGNT),  64'h8);
    checkVal("ar_stb",  64'(bus.STB_O), 64'h1);
    checkVal("ar_we",   64'(bus.WE_O),  64'h1);
    checkVal("ar_dat",  64'(bus.DAT_O), 64'hA5A5);
    #1;
    Reset = 1'b0;
    #1;
    checkVal("ar_cyc0",  64'(bus.CYC_O),  64'h0);
    checkVal("ar_stb0",  64'(bus.STB_O),  64'h0);
    checkVal("ar_gnt0",  64'(bus.oGNT),   64'h0);
    checkVal("ar_adr0",  64'(bus.ADR_O),  64'h0);
    checkVal("ar_we0",   64'(bus.WE_O),   64'h0);
    checkVal("ar_busy0", 64'(bus.oBusy),  64'h0);
    checkVal("ar_own0",  64'(bus.oOwner), 64'h0);
    bus.iCYC = 4'b1001;
    bus.iSTB = 4'b1001;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    waitGrant(gap);
    checkVal("ar_first_gnt", 64'(bus.oGNT), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin arbiter that shares one external Wishbone master port among NUM_REQ requester masters.
- Requesters are per-core IO-unit WBM and TMEM interfaces; each sees a private CYC/STB/ACK/GNT set.
- Sits between the cores' IO units and the memory/texture bus fabric.
- Drives each requester's GNT_I.
- Muxes the winner's ADR/DAT/WE/STB onto the shared bus and routes ACK_I/DAT_I back to the winner only.

Parameters:
- NUM_REQ, 4, number of requester masters (2..8).
- IDX_W, 2, width of owner index, equals clog2(NUM_REQ).
- WB_W, 32, Wishbone address/data width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iCYC  in  NUM_REQ  per-requester bus request (requester CYC_O).
- iSTB  in  NUM_REQ  per-requester strobe.
- iWE  in  NUM_REQ  per-requester write enable.
- iADR  in  NUM_REQ*WB_W  packed requester addresses; slot k at [k*WB_W +: WB_W].
- iDAT  in  NUM_REQ*WB_W  packed requester write data.
- oGNT  out  NUM_REQ  one-hot grant.
- oACK  out  NUM_REQ  ACK routed to owner only.
- oDAT  out  WB_W  read data broadcast; qualify with oACK.
- CYC_O  out  1  shared bus cycle.
- STB_O  out  1  shared bus strobe.
- WE_O  out  1  shared bus write enable.
- ADR_O  out  WB_W  shared bus address.
- DAT_O  out  WB_W  shared bus write data.
- DAT_I  in  WB_W  shared bus read data.
- ACK_I  in  1  shared bus acknowledge.
- oOwner  out  IDX_W  index of current owner; valid while oGNT != 0.
- oBusy  out  1  high in OWN state.

Behaviour:
- Reset (Reset=0, async):
  - State IDLE.
  - oGNT=0, CYC_O=0, STB_O=0, WE_O=0, ADR_O=0, DAT_O=0, oACK=0, oOwner=0, oBusy=0.
  - Last-winner pointer = NUM_REQ-1, so requester 0 has first priority.
  - A mid-transfer Reset drops everything the same cycle. No ACK is forwarded after reset.
- States: IDLE, OWN, RELEASE.
- IDLE:
  - If iCYC != 0, pick the first requester with index strictly after the pointer, with wrap-around.
  - Register oGNT one-hot and oOwner, go to OWN. Latency: request seen at cycle t gives grant at t+1.
  - If iCYC=0, stay in IDLE.
- OWN (w = oOwner):
  - CYC_O=1, oBusy=1.
  - STB_O = iSTB[w] & iCYC[w]. WE_O, ADR_O, DAT_O are combinational muxes of slot w.
  - oACK[w] = ACK_I & CYC_O; all other oACK bits are 0. oDAT = DAT_I.
  - Non-owner requests are held pending and never preempt.
  - When iCYC[w]=0: go to RELEASE, clear oGNT, pointer <= w. An ACK_I arriving in that same cycle is dropped.
- RELEASE:
  - All bus outputs 0 for exactly one turnaround cycle, then IDLE.
  - Handoff to the next requester costs 2 idle bus cycles (RELEASE, IDLE).
- Simultaneous requests: strict rotation. Example: pointer=1 and iCYC=4'b1011 gives winner 3; then 0; then 1.
- Single requester re-requesting is granted again after the 2-cycle gap; no starvation.
- Outside OWN: ADR_O, DAT_O, WE_O are driven 0, not held.
- oGNT is always one-hot or zero; never more than one bit.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entering OWN and on each ACK_I.
  - It increments each OWN cycle with STB_O=1 and ACK_I=0.
  - On reaching TIMEOUT_CYCLES, the arbiter forces RELEASE: grant revoked, pointer advanced past w.
  - Adds output oTimeout (1 bit), which pulses one cycle with oOwner still valid.
  - The revoked requester must drop iCYC before it is regranted. A stale iCYC=1 is treated as a new request only after it has been seen low once.
- Not defined: no counter, no oTimeout port, the owner holds the bus indefinitely.

Decomposition:
- Shared package/defines file (aDefinitions):
  - ARB_IDLE, ARB_OWN, ARB_RELEASE state encodings (2 bits).
  - Default NUM_REQ.
  - WB_WIDTH reuse.
- Sub-module rr_priority_pick:
  - Purely combinational.
  - Inputs: request vector and last pointer. Outputs: one-hot winner and index.
  - Reusable for the TMEM arbiter.

Test Plan:
- Reset then iCYC=4'b0001, iSTB[0]=1, iADR slot0=32'h100 -> oGNT=0001 at t+1; CYC_O=1, ADR_O=32'h100. ACK_I=1, DAT_I=32'hDEADBEEF -> oACK=0001, oDAT=DEADBEEF.
- iCYC=4'b1111 held continuously, each owner drops after 1 ACK -> grant order 0,1,2,3,0. Exactly 2 zero-CYC_O cycles between owners.
- Owner 2 in transfer, requester 1 raises iCYC -> no preemption. oGNT stays 0100 until iCYC[2] falls, then oGNT=0010 two cycles later.
- ACK_I asserted while owner 1 active -> oACK[0], oACK[2], oACK[3] remain 0. ACK_I in the cycle iCYC[1] falls -> no oACK.
- Reset driven low mid-OWN with STB_O=1 -> all outputs 0 immediately (async). After release the first grant goes to requester 0.
- With WB_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8: owner 3 strobes and ACK_I stays 0 -> oTimeout pulses at the 8th stalled cycle, oOwner=3, grant revoked, requester 0 wins next.
